multiport_regfile: RTL and testbench
====================================

Name: multiport_regfile

Overview:
- Clocked successor to the VLIW latch-based register file. NFU functional-unit slices, each with three read ports, one write port and one reserve port.
- Adds:
  - synchronous writes and registered reads;
  - a deterministic rule when two FUs write the same register;
  - a per-register busy scoreboard for in-flight results.
- Sits between the decode/issue stage and the FU execute stages.

Parameters:
- NFU, 2, number of functional units (port slices)
- NREG, 32, number of architectural registers; register 0 is hardwired to zero
- XLEN, 64, register data width
- ADDRW, $clog2(NREG), register index width (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- enable  in  1 x NFU  per-FU slice enable; 0 stalls that slice's reads
- writeEnable  in  1 x NFU  per-FU write request
- writeAddress  in  ADDRW x NFU  write index
- inputData  in  XLEN x NFU  write data
- reserveEnable  in  1 x NFU  mark a destination register busy
- reserveAddress  in  ADDRW x NFU  index to mark busy
- address1/2/3  in  ADDRW x NFU  read indices
- outputData1/2/3  out  XLEN x NFU  registered read data
- outputBusy1/2/3  out  1 x NFU  registered busy flag of the register read
- writeConflict  out  1  registered; two or more FUs wrote the same nonzero register last cycle

Behaviour:
- Reset (rst==0 at posedge): all registers, all outputData*, all outputBusy*, all busy bits and writeConflict go to 0. Reset overrides every other input in that cycle.
- Write:
  - At a posedge with rst==1, FU i writes inputData[i] to writeAddress[i] when writeEnable[i]==1, enable[i]==1 and writeAddress[i]!=0.
  - Writes to register 0 are dropped. Register 0 always reads 0 and is never busy.
- Write conflict:
  - When several qualifying writes target the same register, the highest FU index wins.
  - writeConflict is 1 in the following cycle only; otherwise it is 0.
- Read:
  - Latency 1 cycle. At a posedge with enable[i]==1, outputDataK[i] is loaded with the register at addressK[i], and outputBusyK[i] with its busy bit.
  - With enable[i]==0, slice i's read outputs hold their values.
  - Read data is the pre-write value unless REGFILE_BYPASS_EN is defined.
- Scoreboard:
  - reserveEnable[i] && enable[i] && reserveAddress[i]!=0 sets busy[reserveAddress[i]].
  - A qualifying write clears busy[writeAddress[i]].
  - Same register reserved and written in the same cycle: reserve wins, so busy ends at 1 (a new producer is in flight).
  - Multiple reserves of the same register in one cycle set it once; no error is flagged.
  - The busy flag seen by a read is the pre-update value, or follows the bypass rule below.
- No backpressure. Every write and reserve always completes in one cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose index matches a qualifying write in the same cycle returns the winning write's inputData, not the stale value.
  - Its outputBusyK reports the post-update busy bit.
- Not defined:
  - Reads return the pre-write register value and the pre-update busy bit.
  - Software/issue logic must then allow one extra cycle for a result to become visible.

Decomposition:
- Package regfile_pkg:
  - XLEN default constant;
  - NREG default constant;
  - typedef reg_idx_t (ADDRW-bit index);
  - typedef xword_t (XLEN-bit word);
  - constant REG_ZERO = 0.
- Sub-module regfile_write_arbiter, combinational:
  - takes all NFU write requests;
  - produces per-register write strobe, winning data, conflict flag and busy next-state;
  - used by both the bank update and the bypass path.

Test Plan:
- Reset: hold rst=0 two cycles after random writes -> every read returns 0, busy 0, writeConflict 0.
- Basic write/read: FU0 writes 0xDEAD_BEEF to r5, next cycle FU1 reads r5 -> outputData1[1]=0xDEAD_BEEF one cycle after the read address is applied.
- Conflict: FU0 writes 0x11 and FU1 writes 0x22 to r7 in the same cycle -> r7=0x22; writeConflict=1 for exactly one cycle.
- Register zero: write 0xFFFF to r0, then read r0 on all three ports -> 0. Reserve r0 -> busy stays 0.
- Scoreboard: reserve r3 at cycle N, read r3 at N+1 -> busy=1. Write r3 and re-reserve r3 at N+2 -> busy still 1. Write only at N+3 -> busy=0 on the read after.
- Stall/bypass: enable[0]=0 while r9 changes -> FU0 outputs hold. Same-cycle write and read of r9 with 0x42 -> 0x42 with REGFILE_BYPASS_EN defined, old value without it.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport register file.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREG_DEFAULT  = 32;
  localparam int ADDRW_DEFAULT = $clog2(NREG_DEFAULT);

  // Index of the hardwired-zero register.
  localparam int unsigned REG_ZERO = 0;

  typedef logic [ADDRW_DEFAULT-1:0] reg_idx_t;
  typedef logic [XLEN_DEFAULT-1:0]  xword_t;

endpackage

// File: rtl/multiport_regfile_if.sv
// Issue-side bundle for the register file: one slice of read/write/reserve ports per FU.
// No handshake: every request presented at a rising clk edge completes there; there is no valid/ready pair and no backpressure.
interface multiport_regfile_if #(
  parameter int NFU   = 2,
  parameter int XLEN  = 64,
  parameter int ADDRW = 5
);
  logic [NFU-1:0]            enable;
  logic [NFU-1:0]            writeEnable;
  logic [NFU-1:0][ADDRW-1:0] writeAddress;
  logic [NFU-1:0][XLEN-1:0]  inputData;
  logic [NFU-1:0]            reserveEnable;
  logic [NFU-1:0][ADDRW-1:0] reserveAddress;
  logic [NFU-1:0][ADDRW-1:0] address1;
  logic [NFU-1:0][ADDRW-1:0] address2;
  logic [NFU-1:0][ADDRW-1:0] address3;
  logic [NFU-1:0][XLEN-1:0]  outputData1;
  logic [NFU-1:0][XLEN-1:0]  outputData2;
  logic [NFU-1:0][XLEN-1:0]  outputData3;
  logic [NFU-1:0]            outputBusy1;
  logic [NFU-1:0]            outputBusy2;
  logic [NFU-1:0]            outputBusy3;
  logic                      writeConflict;

  modport master (
    output enable, writeEnable, writeAddress, inputData,
    output reserveEnable, reserveAddress, address1, address2, address3,
    input  outputData1, outputData2, outputData3,
    input  outputBusy1, outputBusy2, outputBusy3, writeConflict
  );

  modport slave (
    input  enable, writeEnable, writeAddress, inputData,
    input  reserveEnable, reserveAddress, address1, address2, address3,
    output outputData1, outputData2, outputData3,
    output outputBusy1, outputBusy2, outputBusy3, writeConflict
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Combinational write arbitration: per-register strobe/data (highest FU wins),
// same-register conflict detection and next busy scoreboard state.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NFU  = 2,
  parameter int NREG = NREG_DEFAULT,
  parameter int XLEN = XLEN_DEFAULT,
  localparam int ADDRW = $clog2(NREG)
) (
  input  logic [NFU-1:0]            enable,
  input  logic [NFU-1:0]            write_en,
  input  logic [NFU-1:0][ADDRW-1:0] write_addr,
  input  logic [NFU-1:0][XLEN-1:0]  write_data,
  input  logic [NFU-1:0]            reserve_en,
  input  logic [NFU-1:0][ADDRW-1:0] reserve_addr,
  input  logic [NREG-1:0]           busy_q,
  output logic [NREG-1:0]           wr_strobe,
  output logic [XLEN-1:0]           wr_data [NREG],
  output logic                      conflict,
  output logic [NREG-1:0]           busy_d
);

  always_comb begin
    wr_strobe = '0;
    wr_data   = '{default: '0};
    conflict  = 1'b0;
    busy_d    = busy_q;
    // Ascending FU order lets the highest-index writer overwrite earlier ones.
    for (int i = 0; i < NFU; i++) begin
      if (write_en[i] && enable[i] && (write_addr[i] != ADDRW'(REG_ZERO))) begin
        if (wr_strobe[write_addr[i]]) conflict = 1'b1;
        wr_strobe[write_addr[i]] = 1'b1;
        wr_data[write_addr[i]]   = write_data[i];
        busy_d[write_addr[i]]    = 1'b0;
      end
    end
    // Reserves applied after write clears: a new in-flight producer keeps the register busy.
    for (int i = 0; i < NFU; i++) begin
      if (reserve_en[i] && enable[i] && (reserve_addr[i] != ADDRW'(REG_ZERO))) begin
        busy_d[reserve_addr[i]] = 1'b1;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

endmodule

// File: rtl/multiport_regfile.sv
// Clocked multiport register file with busy scoreboard and registered reads.
// Define REGFILE_BYPASS_EN to forward same-cycle writes and busy updates to reads.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int NFU  = 2,
  parameter int NREG = NREG_DEFAULT,
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  multiport_regfile_if.slave rf
);

  localparam int ADDRW = $clog2(NREG);

  logic [XLEN-1:0]          regs_q [NREG];
  logic [XLEN-1:0]          regs_d [NREG];
  logic [NREG-1:0]          busy_q, busy_d;
  logic                     conflict_q, conflict_d;
  logic [NREG-1:0]          wr_strobe;
  logic [XLEN-1:0]          wr_data [NREG];
  logic [NFU-1:0][XLEN-1:0] rd_data_q [3];
  logic [NFU-1:0][XLEN-1:0] rd_data_d [3];
  logic [NFU-1:0]           rd_busy_q [3];
  logic [NFU-1:0]           rd_busy_d [3];
  logic [NFU-1:0][ADDRW-1:0] rd_addr [3];
  logic [XLEN-1:0]          view_regs [NREG];
  logic [NREG-1:0]          view_busy;

  regfile_write_arbiter #(.NFU(NFU), .NREG(NREG), .XLEN(XLEN)) u_arbiter (
    .enable       (rf.enable),
    .write_en     (rf.writeEnable),
    .write_addr   (rf.writeAddress),
    .write_data   (rf.inputData),
    .reserve_en   (rf.reserveEnable),
    .reserve_addr (rf.reserveAddress),
    .busy_q       (busy_q),
    .wr_strobe    (wr_strobe),
    .wr_data      (wr_data),
    .conflict     (conflict_d),
    .busy_d       (busy_d)
  );

  assign rd_addr[0] = rf.address1;
  assign rd_addr[1] = rf.address2;
  assign rd_addr[2] = rf.address3;

  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NREG; r++) begin
      if (wr_strobe[r]) regs_d[r] = wr_data[r];
    end
    regs_d[REG_ZERO] = '0;
  end

  always_comb begin
`ifdef REGFILE_BYPASS_EN
    view_regs = regs_d;
    view_busy = busy_d;
`else
    view_regs = regs_q;
    view_busy = busy_q;
`endif
  end

  // A stalled slice keeps its previous read results.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NFU; i++) begin
        if (rf.enable[i]) begin
          rd_data_d[k][i] = view_regs[rd_addr[k][i]];
          rd_busy_d[k][i] = view_busy[rd_addr[k][i]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q     <= '{default: '0};
      busy_q     <= '0;
      conflict_q <= 1'b0;
      rd_data_q  <= '{default: '0};
      rd_busy_q  <= '{default: '0};
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      rd_data_q  <= rd_data_d;
      rd_busy_q  <= rd_busy_d;
    end
  end

  assign rf.outputData1   = rd_data_q[0];
  assign rf.outputData2   = rd_data_q[1];
  assign rf.outputData3   = rd_data_q[2];
  assign rf.outputBusy1   = rd_busy_q[0];
  assign rf.outputBusy2   = rd_busy_q[1];
  assign rf.outputBusy3   = rd_busy_q[2];
  assign rf.writeConflict = conflict_q;

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: directed scenarios plus random traffic against a
// per-register reference model; honours REGFILE_BYPASS_EN like the design.
module tb_multiport_regfile;

  localparam int NFU   = 2;
  localparam int NREG  = 32;
  localparam int XLEN  = 64;
  localparam int ADDRW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  multiport_regfile_if #(.NFU(NFU), .XLEN(XLEN), .ADDRW(ADDRW)) rf_if ();

  multiport_regfile #(.NFU(NFU), .NREG(NREG), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state and expected registered outputs
  logic [XLEN-1:0] m_regs [NREG];
  logic            m_busy [NREG];
  logic [XLEN-1:0] e_data [3][NFU];
  logic            e_busy [3][NFU];
  logic            e_conf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rd_addr(input int k, input int i);
    case (k)
      0:       return int'(rf_if.address1[i]);
      1:       return int'(rf_if.address2[i]);
      default: return int'(rf_if.address3[i]);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] out_data(input int k, input int i);
    case (k)
      0:       return rf_if.outputData1[i];
      1:       return rf_if.outputData2[i];
      default: return rf_if.outputData3[i];
    endcase
  endfunction

  function automatic logic out_busy(input int k, input int i);
    case (k)
      0:       return rf_if.outputBusy1[i];
      1:       return rf_if.outputBusy2[i];
      default: return rf_if.outputBusy3[i];
    endcase
  endfunction

  // driver helpers
  task automatic idle();
    rf_if.enable         = '0;
    rf_if.writeEnable    = '0;
    rf_if.writeAddress   = '0;
    rf_if.inputData      = '0;
    rf_if.reserveEnable  = '0;
    rf_if.reserveAddress = '0;
    rf_if.address1       = '0;
    rf_if.address2       = '0;
    rf_if.address3       = '0;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NFU; i++) begin
      rf_if.enable[i]         = ($urandom_range(0, 3) != 0);
      rf_if.writeEnable[i]    = ($urandom_range(0, 1) != 0);
      rf_if.writeAddress[i]   = ADDRW'($urandom_range(0, 11));
      rf_if.inputData[i]      = {$urandom, $urandom};
      rf_if.reserveEnable[i]  = ($urandom_range(0, 2) == 0);
      rf_if.reserveAddress[i] = ADDRW'($urandom_range(0, 11));
      rf_if.address1[i]       = ADDRW'($urandom_range(0, 11));
      rf_if.address2[i]       = ADDRW'($urandom_range(0, 11));
      rf_if.address3[i]       = ADDRW'($urandom_range(0, 11));
    end
  endtask

  // Advance the model by one clock from the current inputs, clock the DUT, compare everything.
  task automatic tick();
    logic [XLEN-1:0] nregs [NREG];
    logic            nbusy [NREG];
    int              nwr;
    int              a;
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < NFU; i++) begin
          e_data[k][i] = '0;
          e_busy[k][i] = 1'b0;
        end
      e_conf = 1'b0;
    end else begin
      nregs  = m_regs;
      nbusy  = m_busy;
      e_conf = 1'b0;
      for (int r = 1; r < NREG; r++) begin
        nwr = 0;
        for (int i = 0; i < NFU; i++) begin
          if (rf_if.writeEnable[i] && rf_if.enable[i] && int'(rf_if.writeAddress[i]) == r) begin
            nwr++;
            nregs[r] = rf_if.inputData[i];
            nbusy[r] = 1'b0;
          end
        end
        if (nwr > 1) e_conf = 1'b1;
        for (int i = 0; i < NFU; i++) begin
          if (rf_if.reserveEnable[i] && rf_if.enable[i] && int'(rf_if.reserveAddress[i]) == r)
            nbusy[r] = 1'b1;
        end
      end
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < NFU; i++) begin
          if (rf_if.enable[i]) begin
            a = rd_addr(k, i);
            e_data[k][i] = BYPASS ? nregs[a] : m_regs[a];
            e_busy[k][i] = BYPASS ? nbusy[a] : m_busy[a];
          end
        end
      end
      m_regs = nregs;
      m_busy = nbusy;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NFU; i++) begin
        check($sformatf("data%0d[%0d]", k + 1, i), out_data(k, i), e_data[k][i]);
        check($sformatf("busy%0d[%0d]", k + 1, i), 64'(out_busy(k, i)), 64'(e_busy[k][i]));
      end
    end
    check("write_conflict", 64'(rf_if.writeConflict), 64'(e_conf));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    idle();
    tick();
    tick();

    // reset after random writes clears everything
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      randomize_inputs();
      tick();
    end
    rst = 1'b0;
    randomize_inputs();
    tick();
    tick();
    rst = 1'b1;
    idle();
    rf_if.enable = '1;
    for (int i = 0; i < NFU; i++) begin
      rf_if.address1[i] = ADDRW'($urandom_range(1, 11));
      rf_if.address2[i] = ADDRW'($urandom_range(1, 11));
      rf_if.address3[i] = ADDRW'($urandom_range(1, 11));
    end
    tick();
    check("reset_read", rf_if.outputData1[0], 64'h0);

    // basic write then read
    idle();
    rf_if.enable[0] = 1'b1; rf_if.writeEnable[0] = 1'b1;
    rf_if.writeAddress[0] = 5; rf_if.inputData[0] = 64'hDEAD_BEEF;
    tick();
    idle();
    rf_if.enable[1] = 1'b1; rf_if.address1[1] = 5;
    tick();
    check("basic_r5", rf_if.outputData1[1], 64'hDEAD_BEEF);

    // two FUs write r7: FU1 wins, conflict for one cycle
    idle();
    rf_if.enable = '1; rf_if.writeEnable = '1;
    rf_if.writeAddress[0] = 7; rf_if.inputData[0] = 64'h11;
    rf_if.writeAddress[1] = 7; rf_if.inputData[1] = 64'h22;
    tick();
    check("conflict_set", 64'(rf_if.writeConflict), 64'h1);
    idle();
    rf_if.enable[0] = 1'b1; rf_if.address2[0] = 7;
    tick();
    check("conflict_clear", 64'(rf_if.writeConflict), 64'h0);
    check("conflict_winner", rf_if.outputData2[0], 64'h22);

    // register zero ignores writes and reserves
    idle();
    rf_if.enable = '1; rf_if.writeEnable = '1;
    rf_if.inputData[0] = 64'hFFFF; rf_if.inputData[1] = 64'hFFFF;
    rf_if.reserveEnable = '1;
    tick();
    idle();
    rf_if.enable = '1;
    tick();
    check("r0_data3", rf_if.outputData3[1], 64'h0);
    check("r0_busy1", 64'(rf_if.outputBusy1[0]), 64'h0);

    // scoreboard sequence on r3
    idle();
    rf_if.enable[0] = 1'b1; rf_if.reserveEnable[0] = 1'b1; rf_if.reserveAddress[0] = 3;
    tick();
    idle();
    rf_if.enable[0] = 1'b1; rf_if.address1[0] = 3;
    tick();
    check("sb_busy_set", 64'(rf_if.outputBusy1[0]), 64'h1);
    idle();
    rf_if.enable = '1;
    rf_if.writeEnable[1] = 1'b1; rf_if.writeAddress[1] = 3; rf_if.inputData[1] = 64'h33;
    rf_if.reserveEnable[0] = 1'b1; rf_if.reserveAddress[0] = 3;
    tick();
    idle();
    rf_if.enable = '1; rf_if.address1[0] = 3;
    tick();
    check("sb_reserve_wins", 64'(rf_if.outputBusy1[0]), 64'h1);
    idle();
    rf_if.enable[1] = 1'b1; rf_if.writeEnable[1] = 1'b1;
    rf_if.writeAddress[1] = 3; rf_if.inputData[1] = 64'h34;
    tick();
    idle();
    rf_if.enable[0] = 1'b1; rf_if.address1[0] = 3;
    tick();
    check("sb_busy_clear", 64'(rf_if.outputBusy1[0]), 64'h0);

    // stall hold and same-cycle write/read of r9
    idle();
    rf_if.enable[1] = 1'b1; rf_if.writeEnable[1] = 1'b1;
    rf_if.writeAddress[1] = 9; rf_if.inputData[1] = 64'h99;
    tick();
    idle();
    rf_if.enable[0] = 1'b1; rf_if.address1[0] = 9;
    tick();
    check("stall_pre", rf_if.outputData1[0], 64'h99);
    idle();
    rf_if.enable[1] = 1'b1; rf_if.writeEnable[1] = 1'b1;
    rf_if.writeAddress[1] = 9; rf_if.inputData[1] = 64'h55;
    rf_if.address1[0] = 9; rf_if.address1[1] = 2;
    tick();
    check("stall_hold", rf_if.outputData1[0], 64'h99);
    idle();
    rf_if.enable[1] = 1'b1; rf_if.writeEnable[1] = 1'b1;
    rf_if.writeAddress[1] = 9; rf_if.inputData[1] = 64'h42;
    rf_if.address1[1] = 9;
    tick();
    check("bypass_r9", rf_if.outputData1[1], BYPASS ? 64'h42 : 64'h55);

    // random traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) != 0);
      randomize_inputs();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
